// File: rtl/keystroke_sequencer.sv
// keystroke_sequencer: PS/2 scan-code decoder feeding a FIFO of ASCII letters.
// Optional macro TYPEMATIC_FILTER_EN suppresses auto-repeat of a held key.
// overflow is a registered pulse, high in the cycle after the dropped letter was strobed.
module keystroke_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] map_code,
  input  logic [7:0] map_ascii,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;
  state_t state_q;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic is_make, push_req, push, pop, full, empty;
`ifdef TYPEMATIC_FILTER_EN
  logic [7:0] held_q, held_d;
`endif
  assign map_code = scan_code;
  assign empty = count_q == '0;
  assign full = count_q == FULL;
  assign char_valid = !empty;
  assign char_data = empty ? 8'h00 : mem_q[rptr_q];
  assign overflow = overflow_q;
  // Classify the current byte and derive FIFO pointer/occupancy updates.
  always_comb begin
    is_make = scan_valid && state_q == IDLE && scan_code != 8'hF0 && scan_code != 8'hE0;
`ifdef TYPEMATIC_FILTER_EN
    push_req = is_make && map_ascii != 8'h00 && scan_code != held_q;
    held_d = push_req ? scan_code : (scan_valid && state_q == BREAK && scan_code == held_q) ? 8'h00 : held_q;
`else
    push_req = is_make && map_ascii != 8'h00;
`endif
    pop = !empty && char_ready;
    push = push_req && (!full || pop);
    overflow_d = push_req && full && !pop;
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // Prefix decoder; advances only on strobed bytes.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else if (scan_valid)
      state_q <= (state_q == IDLE && scan_code == 8'hF0) ? BREAK :
                 (state_q == IDLE && scan_code == 8'hE0) ? EXT :
                 (state_q == EXT && scan_code == 8'hF0) ? EXT_BREAK : IDLE;
  // FIFO control registers and overflow pulse.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  // Letter storage; contents are only visible while occupancy is non-zero.
  always_ff @(posedge clock)
    if (push) mem_q[wptr_q] <= map_ascii;
`ifdef TYPEMATIC_FILTER_EN
  // Last accepted key, cleared when that key is released.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) held_q <= 8'h00;
    else held_q <= held_d;
`endif
endmodule

// File: tb/tb_keystroke_sequencer.sv
// tb_keystroke_sequencer: table-driven scoreboard bench for keystroke_sequencer.
module tb_keystroke_sequencer;
  logic clock = 1'b0, reset_n = 1'b1, scan_valid = 1'b0, char_ready = 1'b0;
  logic [7:0] scan_code = 8'h00, map_code, map_ascii, char_data;
  logic char_valid, overflow;
`ifdef TYPEMATIC_FILTER_EN
  localparam bit TM = 1'b1;
`else
  localparam bit TM = 1'b0;
`endif
  typedef struct {
    logic [7:0] code;
    logic valid;
    logic ready;
    logic [7:0] letter;
    logic ovf;
  } vec_t;
  vec_t vecs[$];
  logic [7:0] q[$];
  logic [7:0] pend_char = 8'h00;
  logic ovf_pend = 1'b0, ovf_cur = 1'b0, mon_en = 1'b0;
  int compared = 0, mismatched = 0, rst_at;
  keystroke_sequencer #(.FIFO_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .scan_code(scan_code), .scan_valid(scan_valid),
    .map_code(map_code), .map_ascii(map_ascii), .char_data(char_data),
    .char_valid(char_valid), .char_ready(char_ready), .overflow(overflow)
  );
  always #5 clock = ~clock;
  always_comb begin
    map_ascii = 8'h00;
    case (map_code)
      8'h1C: map_ascii = 8'h41;
      8'h32: map_ascii = 8'h42;
      8'h21: map_ascii = 8'h43;
      8'h23: map_ascii = 8'h44;
      8'h24: map_ascii = 8'h45;
      8'h2B: map_ascii = 8'h46;
      default: map_ascii = 8'h00;
    endcase
  end
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic add(input logic [7:0] c, input logic v, input logic r, input logic [7:0] l, input logic o);
    vec_t x;
    x.code = c; x.valid = v; x.ready = r; x.letter = l; x.ovf = o;
    vecs.push_back(x);
  endtask
  task automatic drive(input vec_t v);
    @(posedge clock);
    #1;
    scan_code = v.code;
    scan_valid = v.valid;
    char_ready = v.ready;
    pend_char = v.letter;
    ovf_pend = v.ovf;
  endtask
  always @(negedge clock)
    if (mon_en) begin
      chk("map_code", map_code, scan_code);
      chk("overflow", {7'b0, overflow}, {7'b0, ovf_cur});
      ovf_cur = ovf_pend;
      ovf_pend = 1'b0;
      chk("char_valid", {7'b0, char_valid}, {7'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("char_data", char_data, q[0]);
        if (char_ready) void'(q.pop_front());
      end else chk("char_data_empty", char_data, 8'h00);
      if (pend_char != 8'h00) q.push_back(pend_char);
      pend_char = 8'h00;
    end
  initial begin
    add(8'h1C,1,1,8'h41,0);
    add(8'hF0,1,1,0,0); add(8'h1C,1,1,0,0);
    add(8'h1C,1,1,8'h41,0);
    add(8'hE0,1,1,0,0); add(8'hF0,1,1,0,0); add(8'h75,1,1,0,0);
    add(8'h15,1,1,0,0);
    add(8'hE0,1,1,0,0); add(8'h1C,1,1,0,0);
    add(8'hF0,1,1,0,0); add(8'h1C,1,1,0,0);
    add(8'hF0,0,1,0,0); add(8'h1C,1,1,8'h41,0);
    add(8'hF0,1,1,0,0); add(8'h1C,1,1,0,0);
    add(8'h1C,1,0,8'h41,0); add(8'h32,1,0,8'h42,0); add(8'h21,1,0,8'h43,0); add(8'h23,1,0,8'h44,0);
    add(8'h24,1,0,0,1);
    add(8'h2B,1,1,8'h46,0);
    for (int i = 0; i < 5; i++) add(8'h00,0,1,0,0);
    add(8'h1C,1,0,8'h41,0); add(8'h32,1,0,8'h42,0); add(8'hF0,1,0,0,0);
    rst_at = vecs.size();
    add(8'h1C,1,1,8'h41,0);
    add(8'h00,0,1,0,0); add(8'h00,0,1,0,0);
    add(8'hF0,1,1,0,0); add(8'h1C,1,1,0,0);
    add(8'h1C,1,1,8'h41,0);
    add(8'h1C,1,1,TM ? 8'h00 : 8'h41,0);
    add(8'h1C,1,1,TM ? 8'h00 : 8'h41,0);
    add(8'hF0,1,1,0,0); add(8'h1C,1,1,0,0);
    add(8'h1C,1,1,8'h41,0);
    add(8'h1C,1,1,TM ? 8'h00 : 8'h41,0);
    for (int i = 0; i < 4; i++) add(8'h00,0,1,0,0);
    #1 reset_n = 1'b0;
    #2;
    chk("reset_valid", {7'b0, char_valid}, 8'h00);
    chk("reset_data", char_data, 8'h00);
    chk("reset_ovf", {7'b0, overflow}, 8'h00);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < rst_at; i++) drive(vecs[i]);
    @(posedge clock);
    #1;
    scan_valid = 1'b0;
    #2;
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midreset_valid", {7'b0, char_valid}, 8'h00);
    chk("midreset_data", char_data, 8'h00);
    chk("midreset_ovf", {7'b0, overflow}, 8'h00);
    q.delete();
    ovf_cur = 1'b0; ovf_pend = 1'b0; pend_char = 8'h00;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    for (int i = rst_at; i < vecs.size(); i++) drive(vecs[i]);
    @(posedge clock);
    #1 scan_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 chk("drained", 8'(q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/keystroke_sequencer.md
KEYSTROKE_SEQUENCER -- requirements
Module: keystroke_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered characters (power of two, 2..16).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port scan_code  input  8  byte from PS/2 receiver.
REQ-005 SHALL have port scan_valid  input  1  one-cycle strobe qualifying scan_code.
REQ-006 SHALL have port map_code  output  8  scan code driven to the external scan-to-ASCII lookup.
REQ-007 SHALL have port map_ascii  input  8  combinational lookup result; 8'h00 means unmapped.
REQ-008 SHALL have port char_data  output  8  ASCII letter at FIFO head.
REQ-009 SHALL have port char_valid  output  1  char_data valid; high whenever FIFO is non-empty.
REQ-010 SHALL have port char_ready  input  1  consumer accepts char_data when char_valid && char_ready.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse when a letter is dropped because the FIFO is full.

Function
REQ-012 SHALL drive map_code = scan_code combinationally, every cycle.
REQ-013 SHALL implement decoder states IDLE, BREAK, EXT, EXT_BREAK, changing only on cycles with scan_valid=1.
REQ-014 IDLE: 8'hF0 -> BREAK; 8'hE0 -> EXT; any other byte -> IDLE, treated as a make code.
REQ-015 BREAK: any byte -> IDLE; byte is a released key, never enqueued.
REQ-016 EXT: 8'hF0 -> EXT_BREAK; any other byte -> IDLE, discarded (extended keys are never letters).
REQ-017 EXT_BREAK: any byte -> IDLE, discarded.
REQ-018 A make code in IDLE with map_ascii != 8'h00 SHALL be pushed at the end of that cycle; unmapped make codes are discarded silently.
REQ-019 Latency: letter strobed in cycle N into an empty FIFO SHALL show char_valid=1 and char_data=letter in cycle N+1.
REQ-020 Characters SHALL leave in arrival order; pop occurs on a cycle with char_valid && char_ready.
REQ-021 char_data SHALL be stable while char_valid=1 and char_ready=0.
REQ-022 Full FIFO, push without pop: letter dropped, overflow=1 for that cycle, contents unchanged.
REQ-023 Full FIFO, push with pop in the same cycle: both SHALL occur, no overflow, occupancy unchanged.
REQ-024 Empty FIFO: char_ready ignored, no pop; no same-cycle bypass (REQ-019 holds).
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits.
REQ-026 scan_valid=0 SHALL leave decoder state unchanged, regardless of scan_code value.

Reset
REQ-027 reset_n=0 SHALL immediately force state=IDLE, FIFO empty, char_valid=0, char_data=8'h00, overflow=0.
REQ-028 Reset mid-sequence (e.g., after F0) SHALL discard the pending prefix and all buffered characters.
REQ-029 After reset_n deasserts, the first scan_valid cycle SHALL be decoded from IDLE.

Configuration
REQ-030 Macro TYPEMATIC_FILTER_EN defined: SHALL hold an 8-bit held_code register (reset 8'h00); a mapped make code equal to held_code is discarded; an accepted make code loads held_code; a break of held_code clears it to 8'h00.
REQ-031 Macro TYPEMATIC_FILTER_EN undefined: every mapped make code, including auto-repeats, SHALL be enqueued; no held_code register exists.

Verification
REQ-032 Strobe 8'h1C in IDLE, char_ready=1 -> cycle N+1 char_valid=1, char_data=8'h41 ("A"), popped; FIFO empty at N+2.
REQ-033 Strobe F0,1C -> nothing enqueued, state back to IDLE; strobe E0,F0,75 -> nothing enqueued, IDLE.
REQ-034 char_ready=0, strobe 1C,32,21,23,24 (DEPTH 4) -> FIFO holds A,B,C,D; fifth pulses overflow; then char_ready=1 yields A,B,C,D in order.
REQ-035 Full FIFO, strobe 8'h2B with char_ready=1 same cycle -> A popped, F accepted, no overflow pulse.
REQ-036 Strobe F0 then assert reset_n=0 mid-cycle -> outputs clear immediately; next strobe 8'h1C yields "A".
REQ-037 With TYPEMATIC_FILTER_EN: 1C,1C,1C,F0,1C,1C -> exactly two "A"; without it -> five "A".
